// File: rtl/logic_result_reg_pkg.sv
// Shared execute-path types for the logic-result output stage.
// Provides word/tag types and the occupancy state encoding.
package ee435_pkg;
  localparam int WORD_W    = 32;
  localparam int REG_TAG_W = 5;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REG_TAG_W-1:0] reg_tag_t;

  typedef enum logic [1:0] {
    LRR_EMPTY,
    LRR_ONE,
    LRR_FULL
  } lrr_state_t;
endpackage

// File: rtl/logic_result_reg_if.sv
// Valid/ready result bus between logic unit, result stage and writeback.
// Flag signals exist only when LRR_FLAGS_EN is defined.
interface logic_result_reg_if
  import ee435_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int TAG_W = REG_TAG_W
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic [TAG_W-1:0] tag;
`ifdef LRR_FLAGS_EN
  logic             zero;
  logic             neg;

  modport master (
    output valid, data, tag, zero, neg,
    input  ready
  );
  modport slave (
    input  valid, data, tag, zero, neg,
    output ready
  );
`else
  modport master (
    output valid, data, tag,
    input  ready
  );
  modport slave (
    input  valid, data, tag,
    output ready
  );
`endif
endinterface

// File: rtl/logic_result_reg_slot.sv
// One result holding slot: valid bit, data, tag and optional flags.
// Flags present when LRR_FLAGS_EN is defined.
module lrr_slot
  import ee435_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int TAG_W = REG_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  input  logic [TAG_W-1:0] i_tag,
`ifdef LRR_FLAGS_EN
  input  logic             i_zero,
  input  logic             i_neg,
  output logic             o_zero,
  output logic             o_neg,
`endif
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [TAG_W-1:0] o_tag
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [TAG_W-1:0] r_tag;
  logic             w_load;

  // clear wins; payload is left as-is on clear
  assign w_load = i_load & ~i_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
    end else begin
      if (i_clr) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end
      if (w_load) begin
        r_data <= i_data;
        r_tag  <= i_tag;
      end
    end
  end

`ifdef LRR_FLAGS_EN
  logic r_zero;
  logic r_neg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_load) begin
      r_zero <= i_zero;
      r_neg  <= i_neg;
    end
  end

  assign o_zero = r_zero;
  assign o_neg  = r_neg;
`endif

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_tag   = r_tag;

endmodule

// File: rtl/logic_result_reg.sv
// Registered logic-result stage with one-entry skid; in_ready is a flop.
// Optional zero/neg flags via LRR_FLAGS_EN.
module logic_result_reg
  import ee435_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int TAG_W = REG_TAG_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  logic_result_reg_if.slave         in_if,
  logic_result_reg_if.master        out_if
);

  lrr_state_t       r_state;
  lrr_state_t       w_state_nxt;
  logic             r_in_ready;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_load;
  logic             w_main_clr;
  logic             w_skid_load;
  logic             w_skid_clr;

  logic             w_main_valid;
  logic [WIDTH-1:0] w_main_data;
  logic [TAG_W-1:0] w_main_tag;
  logic             w_skid_valid;
  logic [WIDTH-1:0] w_skid_data;
  logic [TAG_W-1:0] w_skid_tag;
  logic [WIDTH-1:0] w_main_d;
  logic [TAG_W-1:0] w_main_t;

  assign w_in_xfer  = in_if.valid & r_in_ready;
  assign w_out_xfer = w_main_valid & out_if.ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_load = 1'b0;
    w_main_clr  = 1'b0;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    if (flush) begin
      w_state_nxt = LRR_EMPTY;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end else begin
      unique case (r_state)
        LRR_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = LRR_ONE;
            w_main_load = 1'b1;
          end
        end
        LRR_ONE: begin
          unique case (1'b1)
            w_in_xfer & w_out_xfer: begin
              w_main_load = 1'b1;
            end
            w_in_xfer & ~w_out_xfer: begin
              w_state_nxt = LRR_FULL;
              w_skid_load = 1'b1;
            end
            ~w_in_xfer & w_out_xfer: begin
              w_state_nxt = LRR_EMPTY;
              w_main_clr  = 1'b1;
            end
            default: ;
          endcase
        end
        LRR_FULL: begin
          if (w_out_xfer) begin
            w_state_nxt = LRR_ONE;
            w_main_load = 1'b1;
            w_skid_clr  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = LRR_EMPTY;
          w_main_clr  = 1'b1;
          w_skid_clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= LRR_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != LRR_FULL);
    end
  end

  // a valid skid word is always older than anything on the input
  assign w_main_d = w_skid_valid ? w_skid_data : in_if.data;
  assign w_main_t = w_skid_valid ? w_skid_tag  : in_if.tag;

`ifdef LRR_FLAGS_EN
  logic w_in_zero;
  logic w_in_neg;
  logic w_skid_zero;
  logic w_skid_neg;
  logic w_main_zero;
  logic w_main_neg;

  assign w_in_zero = ~|in_if.data;
  assign w_in_neg  = in_if.data[WIDTH-1];
`endif

  lrr_slot #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clr   (w_skid_clr),
    .i_data  (in_if.data),
    .i_tag   (in_if.tag),
`ifdef LRR_FLAGS_EN
    .i_zero  (w_in_zero),
    .i_neg   (w_in_neg),
    .o_zero  (w_skid_zero),
    .o_neg   (w_skid_neg),
`endif
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_tag   (w_skid_tag)
  );

  lrr_slot #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clr   (w_main_clr),
    .i_data  (w_main_d),
    .i_tag   (w_main_t),
`ifdef LRR_FLAGS_EN
    .i_zero  (w_skid_valid ? w_skid_zero : w_in_zero),
    .i_neg   (w_skid_valid ? w_skid_neg  : w_in_neg),
    .o_zero  (w_main_zero),
    .o_neg   (w_main_neg),
`endif
    .o_valid (w_main_valid),
    .o_data  (w_main_data),
    .o_tag   (w_main_tag)
  );

  assign in_if.ready  = r_in_ready;
  assign out_if.valid = w_main_valid;
  assign out_if.data  = w_main_data;
  assign out_if.tag   = w_main_tag;
`ifdef LRR_FLAGS_EN
  assign out_if.zero  = w_main_zero;
  assign out_if.neg   = w_main_neg;
`endif

endmodule

// File: tb/tb_logic_result_reg.sv
// Scoreboard bench for logic_result_reg: directed cases then random traffic.
// Flag checks compiled in with LRR_FLAGS_EN.
module tb_logic_result_reg;
  import ee435_pkg::*;

  typedef struct packed {
    reg_tag_t tag;
    word_t    data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  logic_result_reg_if up_if ();
  logic_result_reg_if dn_if ();

  logic_result_reg u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .in_if  (up_if),
    .out_if (dn_if)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_deliv = 0;
  bit   armed   = 1'b0;
  bit   was_stall = 1'b0;
  exp_t hold_v;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, word_t d, reg_tag_t t);
    up_if.valid = v;
    up_if.data  = d;
    up_if.tag   = t;
  endtask

  // queue holds exactly the words the stage should be holding
  always @(negedge clk) begin : mon
    exp_t e;
    if (armed) begin
      chk("occ_valid", dn_if.valid, q.size() != 0);
      chk("occ_ready", up_if.ready, q.size() < 2);
      if (was_stall) chk("hold", {dn_if.tag, dn_if.data}, hold_v);
      was_stall = rst_n && !flush && dn_if.valid && !dn_if.ready;
      hold_v    = {dn_if.tag, dn_if.data};
      if (!rst_n || flush) begin
        q.delete();
      end else begin
        if (dn_if.valid && dn_if.ready) begin
          if (q.size() == 0) begin
            chk("sb_empty", dn_if.valid, 1'b0);
          end else begin
            e = q.pop_front();
            chk("sb_data", dn_if.data, e.data);
            chk("sb_tag", dn_if.tag, e.tag);
`ifdef LRR_FLAGS_EN
            chk("sb_zero", dn_if.zero, e.data == '0);
            chk("sb_neg", dn_if.neg, e.data[WORD_W-1]);
`endif
            n_deliv++;
          end
        end
        if (up_if.valid && up_if.ready)
          q.push_back({up_if.tag, up_if.data});
      end
    end
    if (!rst_n) armed = 1'b1;
  end

  initial begin : main
    int  cyc;
    int  start;
    bit  did_rst;
`ifdef LRR_FLAGS_EN
    up_if.zero = 1'b0;
    up_if.neg  = 1'b0;
`endif
    dn_if.ready = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 5'd9);

    // reset with input asserted
    rst_n = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_valid", dn_if.valid, 1'b0);
    chk("rst_ready", up_if.ready, 1'b1);
    chk("rst_data", dn_if.data, 32'h0);
    chk("rst_tag", dn_if.tag, 5'd0);

    // streaming
    step();
    rst_n = 1'b1;
    drive(1'b0, '0, '0);
    dn_if.ready = 1'b1;
    step();
    drive(1'b1, 32'hFFFF0000, 5'd3);
    @(negedge clk);
    chk("s_rdy0", up_if.ready, 1'b1);
    step();
    drive(1'b1, 32'h0000FFFF, 5'd4);
    @(negedge clk);
    chk("s_out0", dn_if.data, 32'hFFFF0000);
    chk("s_tag0", dn_if.tag, 5'd3);
    chk("s_rdy1", up_if.ready, 1'b1);
    step();
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("s_out1", dn_if.data, 32'h0000FFFF);
    chk("s_tag1", dn_if.tag, 5'd4);
    step();
    @(negedge clk);
    chk("s_idle", dn_if.valid, 1'b0);

    // backpressure into the skid
    step();
    dn_if.ready = 1'b0;
    drive(1'b1, 32'hA5A5A5A5, 5'd7);
    @(negedge clk);
    chk("bp_rdy0", up_if.ready, 1'b1);
    step();
    drive(1'b1, 32'h5A5A5A5A, 5'd8);
    @(negedge clk);
    chk("bp_out0", dn_if.data, 32'hA5A5A5A5);
    step();
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("bp_full", up_if.ready, 1'b0);
    chk("bp_out1", dn_if.data, 32'hA5A5A5A5);
    step();
    @(negedge clk);
    chk("bp_hold", dn_if.data, 32'hA5A5A5A5);
    step();
    dn_if.ready = 1'b1;
    @(negedge clk);
    chk("bp_drain0", dn_if.data, 32'hA5A5A5A5);
    step();
    @(negedge clk);
    chk("bp_rdy1", up_if.ready, 1'b1);
    chk("bp_drain1", dn_if.data, 32'h5A5A5A5A);
    chk("bp_tag1", dn_if.tag, 5'd8);
    step();
    @(negedge clk);
    chk("bp_idle", dn_if.valid, 1'b0);

    // flush while full, with input and output both requesting
    step();
    dn_if.ready = 1'b0;
    drive(1'b1, 32'h11111111, 5'd1);
    step();
    drive(1'b1, 32'h22222222, 5'd2);
    step();
    drive(1'b1, 32'h33333333, 5'd3);
    dn_if.ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_full", up_if.ready, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("fl_valid", dn_if.valid, 1'b0);
    chk("fl_ready", up_if.ready, 1'b1);
    step();
    @(negedge clk);
    chk("fl_quiet", dn_if.valid, 1'b0);

`ifdef LRR_FLAGS_EN
    step();
    drive(1'b1, 32'h00000000, 5'd0);
    step();
    drive(1'b1, 32'h80000000, 5'd10);
    @(negedge clk);
    chk("f_zero0", dn_if.zero, 1'b1);
    chk("f_neg0", dn_if.neg, 1'b0);
    step();
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("f_zero1", dn_if.zero, 1'b0);
    chk("f_neg1", dn_if.neg, 1'b1);
`endif

    // random traffic with one mid-run reset pulse
    cyc     = 0;
    did_rst = 1'b0;
    start   = n_deliv;
    while ((n_deliv - start) < 10000 && cyc < 60000) begin
      step();
      drive($urandom_range(0, 9) < 7, $urandom,
            reg_tag_t'($urandom_range(0, 31)));
      dn_if.ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 199) == 0;
      if (!did_rst && (n_deliv - start) >= 5000) begin
        rst_n   = 1'b0;
        did_rst = 1'b1;
      end else begin
        rst_n = 1'b1;
      end
      cyc++;
    end
    chk("rnd_count", (n_deliv - start) >= 10000, 1'b1);

    step();
    drive(1'b0, '0, '0);
    flush       = 1'b0;
    rst_n       = 1'b1;
    dn_if.ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
